lacc_mem_responder: RTL and testbench
=====================================

LACC_MEM_RESPONDER -- requirements
Module: lacc_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0001_0000, byte address of scratchpad word 0.
REQ-002 SHALL have parameter DEPTH, default 1024, scratchpad size in 32-bit words (power of two).
REQ-003 SHALL have ports: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-004 SHALL have lacc_data_valid input 1, accelerator request valid; lacc_data_ready output 1, request accepted.
REQ-005 SHALL have lacc_data_addr input 32, byte address; lacc_data_read input 1, 1=read 0=write; lacc_data_wdata input 32, lane-aligned write data; lacc_data_size input 2, 0=byte 1=half 2/3=word.
REQ-006 SHALL have lacc_drsp_valid output 1, read response; lacc_drsp_rdata output 32, aligned read word.
REQ-007 SHALL have host_req_valid input 1; host_req_ready output 1; host_req_we input 1; host_req_addr input 32; host_req_wdata input 32; host_req_wstrb input 4; host_rsp_valid output 1; host_rsp_rdata output 32.
REQ-008 SHALL have clear_req input 1, start scratchpad zeroing; clear_busy output 1, zeroing in progress.
REQ-009 SHALL have err_valid output 1, one-cycle out-of-range pulse; err_addr output 32, offending address.

Function
REQ-010 Handshake: request transfers when valid & ready on the same edge; ready SHALL depend only on state, grant and valids (no dependence on rdata).
REQ-011 Read latency: lacc_drsp_valid SHALL assert exactly 1 cycle after an accepted lacc read, never otherwise; same rule for host_rsp_valid on host reads.
REQ-012 Writes SHALL generate no response.
REQ-013 Lacc byte enables: size 0 -> bit addr[1:0]; size 1 -> bits {addr[1],0}+{0,1}; size 2/3 -> all four; addr[1:0] ignored for word.
REQ-014 Host byte enables SHALL equal host_req_wstrb.
REQ-015 Word index = (addr - BASE_ADDR)[log2(DEPTH)+1:2]; in range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH.
REQ-016 Out-of-range request SHALL still be accepted; read returns 32'h0 with normal latency; write dropped; err_valid pulses 1 cycle later with err_addr = address (lacc wins if both erroneous same cycle -- impossible by REQ-017).
REQ-017 Arbitration: at most one port granted per cycle; sole requester granted; on conflict the port not granted last conflict wins (pointer resets to lacc-first); pointer updates only on conflicts.
REQ-018 FSM states IDLE, CLEAR; IDLE->CLEAR on clear_req while IDLE (takes priority over same-cycle requests, which are not accepted); CLEAR writes zero to index 0,1,..DEPTH-1 one per cycle; CLEAR->IDLE after index DEPTH-1 written; clear_req in CLEAR ignored.
REQ-019 clear_busy SHALL be high exactly in CLEAR; both ready outputs low in CLEAR.
REQ-020 Read data in the response cycle SHALL reflect all writes accepted in earlier cycles.
REQ-021 Responses of a read accepted in the last IDLE cycle before CLEAR SHALL still be delivered.

Reset
REQ-022 On rst: FSM IDLE, clear index 0, arbitration pointer lacc-first, lacc_drsp_valid 0, lacc_drsp_rdata 0, host_rsp_valid 0, host_rsp_rdata 0, err_valid 0, err_addr 0, clear_busy 0.
REQ-023 Reset mid-CLEAR SHALL return to IDLE; scratchpad contents then undefined; no pending response survives reset.

Structure
REQ-024 Shared package lacc_mem_pkg SHALL hold size encodings, FSM state encoding, address width constant.
REQ-025 One sub-module lacc_spram: single-port byte-write RAM, DEPTH x 32, 1-cycle registered read.

Verification
REQ-026 Lacc write word 32'hDEADBEEF @BASE+0x10, then read same -> drsp_valid exactly 1 cycle after read handshake, rdata 32'hDEADBEEF.
REQ-027 Lacc byte write size 0, addr BASE+0x13, wdata 32'hAA000000 over 32'h11223344 -> read gives 32'hAA223344.
REQ-028 Both ports valid 4 consecutive cycles -> grants alternate lacc,host,lacc,host; each read answered 1 cycle later on its own port.
REQ-029 Lacc read @BASE+4*DEPTH -> accepted, rdata 0, err_valid 1 cycle with err_addr = BASE+4*DEPTH.
REQ-030 clear_req with DEPTH=16 -> clear_busy high 16 cycles, readies low; afterwards all words read 0.
REQ-031 rst asserted at clear index 5 -> outputs reset values immediately; next cycle IDLE, ready accepts requests.

Source files
------------

// File: rtl/lacc_mem_responder_pkg.sv
// Shared definitions for the accelerator scratchpad responder.
package lacc_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'd0,
    SZ_HALF     = 2'd1,
    SZ_WORD     = 2'd2,
    SZ_WORD_ALT = 2'd3
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic logic [3:0] lacc_byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size_e'(size))
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lacc_mem_responder_if.sv
// Accelerator data port and host port bundle; master drives requests, slave answers.
interface lacc_mem_responder_if;
  import lacc_mem_pkg::*;

  logic              lacc_data_valid;
  logic              lacc_data_ready;
  logic [ADDR_W-1:0] lacc_data_addr;
  logic              lacc_data_read;
  logic [DATA_W-1:0] lacc_data_wdata;
  logic [1:0]        lacc_data_size;
  logic              lacc_drsp_valid;
  logic [DATA_W-1:0] lacc_drsp_rdata;

  logic              host_req_valid;
  logic              host_req_ready;
  logic              host_req_we;
  logic [ADDR_W-1:0] host_req_addr;
  logic [DATA_W-1:0] host_req_wdata;
  logic [3:0]        host_req_wstrb;
  logic              host_rsp_valid;
  logic [DATA_W-1:0] host_rsp_rdata;

  modport master (
    output lacc_data_valid, lacc_data_addr, lacc_data_read, lacc_data_wdata, lacc_data_size,
    input  lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata,
    output host_req_valid, host_req_we, host_req_addr, host_req_wdata, host_req_wstrb,
    input  host_req_ready, host_rsp_valid, host_rsp_rdata
  );

  modport slave (
    input  lacc_data_valid, lacc_data_addr, lacc_data_read, lacc_data_wdata, lacc_data_size,
    output lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata,
    input  host_req_valid, host_req_we, host_req_addr, host_req_wdata, host_req_wstrb,
    output host_req_ready, host_rsp_valid, host_rsp_rdata
  );

endinterface

// File: rtl/lacc_mem_responder_spram.sv
// Single-port byte-write RAM with a registered read port (output holds between reads).
module lacc_spram #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_q <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/lacc_mem_responder.sv
// Scratchpad shared by the accelerator data port and a host port, with fair
// arbitration, out-of-range error reporting and a sequential zeroing engine.
module lacc_mem_responder
  import lacc_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned       DEPTH     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  lacc_mem_responder_if.slave   bus,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  err_valid,
  output logic [ADDR_W-1:0]     err_addr
);

  localparam int unsigned       AW   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * DEPTH);

  state_e            r_state, w_state_nxt;
  logic [AW-1:0]     r_clr_idx;
  logic              r_prio_host;
  logic              r_lacc_rsp, r_host_rsp, r_rsp_oor;
  logic              r_err_valid;
  logic [ADDR_W-1:0] r_err_addr;

  logic              w_idle, w_lacc_gnt, w_host_gnt, w_conflict, w_acc;
  logic [ADDR_W-1:0] w_addr, w_offset;
  logic [DATA_W-1:0] w_wdata, w_ram_wdata, w_ram_q;
  logic [3:0]        w_be, w_ram_be;
  logic              w_rd, w_in_range;
  logic              w_ram_en, w_ram_we;
  logic [AW-1:0]     w_ram_idx;

  // clear_req beats any same-cycle request; on conflict r_prio_host picks the winner
  assign w_idle     = (r_state == ST_IDLE) && !clear_req;
  assign w_conflict = w_idle && bus.lacc_data_valid && bus.host_req_valid;
  assign w_lacc_gnt = w_idle && bus.lacc_data_valid && !(bus.host_req_valid && r_prio_host);
  assign w_host_gnt = w_idle && bus.host_req_valid && !w_lacc_gnt;
  assign w_acc      = w_lacc_gnt || w_host_gnt;

  assign bus.lacc_data_ready = w_lacc_gnt;
  assign bus.host_req_ready  = w_host_gnt;

  always_comb begin
    w_addr  = bus.host_req_addr;
    w_rd    = !bus.host_req_we;
    w_be    = bus.host_req_wstrb;
    w_wdata = bus.host_req_wdata;
    if (w_lacc_gnt) begin
      w_addr  = bus.lacc_data_addr;
      w_rd    = bus.lacc_data_read;
      w_be    = lacc_byte_en(bus.lacc_data_size, bus.lacc_data_addr[1:0]);
      w_wdata = bus.lacc_data_wdata;
    end
  end

  assign w_offset   = w_addr - BASE_ADDR;
  assign w_in_range = (w_addr >= BASE_ADDR) && (w_offset < SPAN);

  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_be    = '0;
    w_ram_idx   = '0;
    w_ram_wdata = '0;
    if (r_state == ST_CLEAR) begin
      w_ram_en  = 1'b1;
      w_ram_we  = 1'b1;
      w_ram_be  = '1;
      w_ram_idx = r_clr_idx;
    end else if (w_acc && w_in_range) begin
      w_ram_en    = 1'b1;
      w_ram_we    = !w_rd;
      w_ram_be    = w_be;
      w_ram_idx   = w_offset[AW+1:2];
      w_ram_wdata = w_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clear_req) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_clr_idx == AW'(DEPTH - 1)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_clr_idx   <= '0;
      r_prio_host <= 1'b0;
      r_lacc_rsp  <= 1'b0;
      r_host_rsp  <= 1'b0;
      r_rsp_oor   <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_idx   <= (r_state == ST_CLEAR) ? r_clr_idx + 1'b1 : '0;
      if (w_conflict) r_prio_host <= w_lacc_gnt;
      r_lacc_rsp  <= w_lacc_gnt && bus.lacc_data_read;
      r_host_rsp  <= w_host_gnt && !bus.host_req_we;
      r_rsp_oor   <= !w_in_range;
      r_err_valid <= w_acc && !w_in_range;
      if (w_acc && !w_in_range) r_err_addr <= w_addr;
    end
  end

  lacc_spram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_idx   (w_ram_idx),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );

  // read data is gated so it reads zero outside response cycles and after reset
  assign bus.lacc_drsp_valid = r_lacc_rsp;
  assign bus.lacc_drsp_rdata = (r_lacc_rsp && !r_rsp_oor) ? w_ram_q : '0;
  assign bus.host_rsp_valid  = r_host_rsp;
  assign bus.host_rsp_rdata  = (r_host_rsp && !r_rsp_oor) ? w_ram_q : '0;
  assign clear_busy          = (r_state == ST_CLEAR);
  assign err_valid           = r_err_valid;
  assign err_addr            = r_err_addr;

endmodule

// File: tb/tb_lacc_mem_responder.sv
// Scoreboard bench: driver predicts grants/responses from a word-array model,
// a negedge monitor pops expectations whenever the responder answers.
module tb_lacc_mem_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req, clear_busy, err_valid;
  logic [31:0] err_addr;

  always #5 clk = ~clk;

  lacc_mem_responder_if bus();

  lacc_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .err_valid  (err_valid),
    .err_addr   (err_addr)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [DEPTH];
  bit          lacc_won_last;
  int          clr_left;
  int          busy_cycles;
  bit          mon_en = 1'b0;
  logic [31:0] lq[$], hq[$], eq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    longint ua = longint'(a);
    return (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] en);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [3:0] lanes_for(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] en = '0;
    for (int b = 0; b < 4; b++)
      en[b] = (sz >= 2) || (sz == 1 && (b / 2) == int'(a[1])) || (sz == 0 && b == int'(a[1:0]));
    return en;
  endfunction

  task automatic do_cycle(input bit lv, input logic [31:0] la, input bit lr, input logic [31:0] lw,
                          input logic [1:0] lsz, input bit hv, input bit hwe, input logic [31:0] ha,
                          input logic [31:0] hw, input logic [3:0] hs, input bit clr);
    bit busy, idle, lg, hg;
    @(negedge clk);
    bus.lacc_data_valid = lv; bus.lacc_data_addr = la; bus.lacc_data_read = lr;
    bus.lacc_data_wdata = lw; bus.lacc_data_size = lsz;
    bus.host_req_valid = hv; bus.host_req_we = hwe; bus.host_req_addr = ha;
    bus.host_req_wdata = hw; bus.host_req_wstrb = hs;
    clear_req = clr;
    #4;
    busy = (clr_left > 0);
    idle = !busy && !clr;
    lg   = idle && lv && !(hv && lacc_won_last);
    hg   = idle && hv && !lg;
    check("lacc_ready", {31'b0, bus.lacc_data_ready}, {31'b0, lg});
    check("host_ready", {31'b0, bus.host_req_ready}, {31'b0, hg});
    check("clear_busy", {31'b0, clear_busy}, {31'b0, busy});
    if (busy) busy_cycles++;
    if (idle && lv && hv) lacc_won_last = lg;
    if (busy) clr_left--;
    else if (clr) begin
      clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end
    if (lg) begin
      if (lr) lq.push_back(in_range(la) ? mem[widx(la)] : 32'h0);
      else if (in_range(la)) mem[widx(la)] = merge(mem[widx(la)], lw, lanes_for(lsz, la));
      if (!in_range(la)) eq.push_back(la);
    end
    if (hg) begin
      if (!hwe) hq.push_back(in_range(ha) ? mem[widx(ha)] : 32'h0);
      else if (in_range(ha)) mem[widx(ha)] = merge(mem[widx(ha)], hw, hs);
      if (!in_range(ha)) eq.push_back(ha);
    end
  endtask

  task automatic idle_cycle();
    do_cycle(0, '0, 0, '0, 2'd0, 0, 0, '0, '0, 4'h0, 0);
  endtask

  task automatic lacc_op(input logic [31:0] a, input bit rd, input logic [31:0] wd, input logic [1:0] sz);
    do_cycle(1, a, rd, wd, sz, 0, 0, '0, '0, 4'h0, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [31:0] e;
      check("lacc_drsp_valid", {31'b0, bus.lacc_drsp_valid}, {31'b0, lq.size() != 0});
      if (lq.size() != 0) begin
        e = lq.pop_front();
        if (bus.lacc_drsp_valid) check("lacc_drsp_rdata", bus.lacc_drsp_rdata, e);
      end
      check("host_rsp_valid", {31'b0, bus.host_rsp_valid}, {31'b0, hq.size() != 0});
      if (hq.size() != 0) begin
        e = hq.pop_front();
        if (bus.host_rsp_valid) check("host_rsp_rdata", bus.host_rsp_rdata, e);
      end
      check("err_valid", {31'b0, err_valid}, {31'b0, eq.size() != 0});
      if (eq.size() != 0) begin
        e = eq.pop_front();
        if (err_valid) check("err_addr", err_addr, e);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_drsp_valid"}, {31'b0, bus.lacc_drsp_valid}, 32'h0);
    check({tag, "_drsp_rdata"}, bus.lacc_drsp_rdata, 32'h0);
    check({tag, "_hrsp_valid"}, {31'b0, bus.host_rsp_valid}, 32'h0);
    check({tag, "_hrsp_rdata"}, bus.host_rsp_rdata, 32'h0);
    check({tag, "_err_valid"}, {31'b0, err_valid}, 32'h0);
    check({tag, "_err_addr"}, err_addr, 32'h0);
    check({tag, "_clear_busy"}, {31'b0, clear_busy}, 32'h0);
  endtask

  task automatic full_clear_and_verify();
    busy_cycles = 0;
    do_cycle(1, BASE, 1, '0, 2'd2, 1, 0, BASE + 4, '0, 4'h0, 1);
    for (int i = 0; i < DEPTH + 1; i++) idle_cycle();
    check("clear_busy_cycles", busy_cycles, DEPTH);
    for (int i = 0; i < DEPTH; i++) lacc_op(BASE + 32'(4 * i), 1, '0, 2'd2);
  endtask

  initial begin
    rst = 1'b1;
    clear_req = 1'b0;
    bus.lacc_data_valid = 0; bus.lacc_data_addr = '0; bus.lacc_data_read = 0;
    bus.lacc_data_wdata = '0; bus.lacc_data_size = '0;
    bus.host_req_valid = 0; bus.host_req_we = 0; bus.host_req_addr = '0;
    bus.host_req_wdata = '0; bus.host_req_wstrb = '0;
    lacc_won_last = 1'b0;
    clr_left = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    mon_en = 1'b1;

    full_clear_and_verify();

    lacc_op(BASE + 32'h10, 0, 32'hDEADBEEF, 2'd2);
    lacc_op(BASE + 32'h10, 1, '0, 2'd2);
    idle_cycle();
    lacc_op(BASE + 32'h10, 0, 32'h11223344, 2'd2);
    lacc_op(BASE + 32'h13, 0, 32'hAA000000, 2'd0);
    lacc_op(BASE + 32'h10, 1, '0, 2'd2);
    lacc_op(BASE + 32'h22, 0, 32'hBEEF0000, 2'd1);
    lacc_op(BASE + 32'h20, 1, '0, 2'd3);

    for (int i = 0; i < 4; i++)
      do_cycle(1, BASE + 32'h10, 1, '0, 2'd2, 1, 0, BASE + 32'h20, '0, 4'h0, 0);
    do_cycle(0, '0, 0, '0, 2'd0, 1, 1, BASE + 32'h8, 32'hCAFEF00D, 4'b0101, 0);
    do_cycle(0, '0, 0, '0, 2'd0, 1, 0, BASE + 32'h8, '0, 4'h0, 0);

    lacc_op(BASE + 32'(4 * DEPTH), 1, '0, 2'd2);
    lacc_op(BASE - 32'h4, 0, 32'h12345678, 2'd2);
    do_cycle(0, '0, 0, '0, 2'd0, 1, 0, BASE + 32'(4 * DEPTH) + 32'h8, '0, 4'h0, 0);
    idle_cycle();

    for (int n = 0; n < 400; n++) begin
      logic [31:0] la, ha;
      la = ($urandom_range(0, 9) == 0) ? BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15))
                                       : BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      ha = ($urandom_range(0, 9) == 0) ? BASE - 32'($urandom_range(1, 8))
                                       : BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      do_cycle($urandom_range(0, 2) != 0, la, $urandom_range(0, 1) == 1, $urandom,
               2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
               ha, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 59) == 0);
    end
    while (clr_left > 0) idle_cycle();
    idle_cycle();

    do_cycle(0, '0, 0, '0, 2'd0, 0, 0, '0, '0, 4'h0, 1);
    repeat (5) idle_cycle();
    @(posedge clk);
    #2;
    check("busy_before_rst", {31'b0, clear_busy}, 32'h1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midclr");
    clr_left = 0;
    lacc_won_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lacc_op(BASE + 32'h4, 0, 32'h0BADF00D, 2'd2);
    full_clear_and_verify();
    repeat (2) idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
